// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - registered N:1 mux with internal fixed-priority / round-robin arbiter
module arb_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int RR_MODE = 1,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic [WIDTH-1:0]         res,
    output logic [SEL_W-1:0]         res_sel,
    output logic                     res_valid,
    input  logic                     res_ready
);

    logic             can_load;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    int               scan_idx;

    // Output register may accept a new word when empty or being drained now
    assign can_load = !res_valid || res_ready;

    // Search for the first valid channel, starting at ptr (round-robin) or 0 (fixed)
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RR_MODE != 0) begin
                scan_idx = int'(ptr) + k;
                if (scan_idx >= NUM_SRC) begin
                    scan_idx = scan_idx - NUM_SRC;
                end
            end else begin
                scan_idx = k;
            end
            if (!grant_found && src_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(scan_idx);
                grant_data  = src_data[scan_idx*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready for the winner only; silent in reset or while stalled
    always_comb begin
        src_ready = '0;
        if (!rst && can_load && grant_found) begin
            src_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer advances past the channel just served, wrapping at the top
    always_comb begin
        if (grant_idx == SEL_W'(NUM_SRC - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // Output register, selection index and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            res_sel   <= '0;
            res_valid <= 1'b0;
            ptr       <= '0;
        end else if (can_load) begin
            if (grant_found) begin
                res       <= grant_data;
                res_sel   <= grant_idx;
                res_valid <= 1'b1;
                if (RR_MODE != 0) begin
                    ptr <= ptr_next;
                end
            end else begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - directed scoreboard bench for arb_mux (round-robin and fixed-priority)
module tb_arb_mux;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [WIDTH-1:0]         data [NUM_SRC];
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_valid;
    logic                     res_ready;

    logic [NUM_SRC-1:0] rr_src_ready, fp_src_ready;
    logic [WIDTH-1:0]   rr_res, fp_res;
    logic [SEL_W-1:0]   rr_res_sel, fp_res_sel;
    logic               rr_res_valid, fp_res_valid;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    assign src_data = {data[3], data[2], data[1], data[0]};

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
        .src_ready(rr_src_ready), .res(rr_res), .res_sel(rr_res_sel),
        .res_valid(rr_res_valid), .res_ready(res_ready)
    );

    arb_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
        .src_ready(fp_src_ready), .res(fp_res), .res_sel(fp_res_sel),
        .res_valid(fp_res_valid), .res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] d);
        exp_t e;
        e.sel  = sel;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Compare the round-robin output register against the oldest expected word
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(rr_res_valid), 64'd1);
            chk({tag, "_sel"}, 64'(rr_res_sel), 64'(e.sel));
            chk({tag, "_data"}, 64'(rr_res), 64'(e.data));
        end
    endtask

    initial begin
        // Reset with every source valid
        rst       = 1'b1;
        res_ready = 1'b1;
        src_valid = 4'b1111;
        for (int i = 0; i < NUM_SRC; i++) data[i] = 32'h1000 + i;
        tick();
        tick();
        chk("rst_rr_ready", 64'(rr_src_ready), 64'h0);
        chk("rst_fp_ready", 64'(fp_src_ready), 64'h0);
        chk("rst_rr_valid", 64'(rr_res_valid), 64'h0);
        chk("rst_fp_valid", 64'(fp_res_valid), 64'h0);
        chk("rst_rr_res", 64'(rr_res), 64'h0);
        chk("rst_rr_sel", 64'(rr_res_sel), 64'h0);

        // Release: round-robin sweeps 0,1,2,3,0,1,2,3; fixed priority stays on 0
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_ready_%0d", i), 64'(rr_src_ready), 64'(4'b0001 << (i % 4)));
            push(SEL_W'(i % 4), 32'h1000 + (i % 4));
            tick();
            pop_check($sformatf("rr_seq_%0d", i));
            chk($sformatf("fp_sel_%0d", i), 64'(fp_res_sel), 64'h0);
        end

        // Fixed priority with channels 1 and 3 valid: 1 always wins
        src_valid = 4'b1010;
        #1;
        chk("fp_ready_13", 64'(fp_src_ready), 64'b0010);
        push(2'd1, 32'h1001);
        push(2'd3, 32'h1003);
        push(2'd1, 32'h1001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fp13_sel_%0d", i), 64'(fp_res_sel), 64'd1);
            chk($sformatf("fp13_data_%0d", i), 64'(fp_res), 64'h1001);
            chk($sformatf("fp13_ready_%0d", i), 64'(fp_src_ready), 64'b0010);
            pop_check($sformatf("rr13_%0d", i));
        end

        // Load DEADBEEF on channel 0 (rr pointer is at 2, wraps to 0)
        data[0]   = 32'hDEADBEEF;
        src_valid = 4'b0001;
        push(2'd0, 32'hDEADBEEF);
        tick();
        pop_check("bp_load");

        // Backpressure for 3 cycles with channel 2 pending
        res_ready = 1'b0;
        data[2]   = 32'h2222_2222;
        src_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready_%0d", i), 64'(rr_src_ready), 64'h0);
            chk($sformatf("bp_fp_ready_%0d", i), 64'(fp_src_ready), 64'h0);
            tick();
            chk($sformatf("bp_res_%0d", i), 64'(rr_res), 64'hDEADBEEF);
            chk($sformatf("bp_sel_%0d", i), 64'(rr_res_sel), 64'h0);
            chk($sformatf("bp_valid_%0d", i), 64'(rr_res_valid), 64'h1);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(rr_src_ready), 64'b0100);
        push(2'd2, 32'h2222_2222);
        tick();
        pop_check("bp_release");

        // Drain to empty: a single word from channel 0 (pointer at 3, wraps to 0)
        data[0]   = 32'h5555_5555;
        src_valid = 4'b0001;
        push(2'd0, 32'h5555_5555);
        tick();
        pop_check("drain_word");
        src_valid = 4'b0000;
        #1;
        chk("drain_idle_ready", 64'(rr_src_ready), 64'h0);
        tick();
        chk("drain_valid", 64'(rr_res_valid), 64'h0);
        chk("drain_stale_res", 64'(rr_res), 64'h5555_5555);
        chk("drain_stale_sel", 64'(rr_res_sel), 64'h0);
        tick();
        chk("drain_valid_2", 64'(rr_res_valid), 64'h0);

        // Pointer should now sit at 1
        src_valid = 4'b1111;
        #1;
        chk("drain_ptr", 64'(rr_src_ready), 64'b0010);
        push(2'd1, 32'h1001);
        tick();
        pop_check("after_drain");

        // Asynchronous reset mid-stream while the register holds data
        rst = 1'b1;
        #1;
        chk("arst_rr_valid", 64'(rr_res_valid), 64'h0);
        chk("arst_fp_valid", 64'(fp_res_valid), 64'h0);
        chk("arst_rr_ready", 64'(rr_src_ready), 64'h0);
        tick();
        rst       = 1'b0;
        data[2]   = 32'h0000_2002;
        src_valid = 4'b1100;
        #1;
        chk("post_rst_rr_ready", 64'(rr_src_ready), 64'b0100);
        chk("post_rst_fp_ready", 64'(fp_src_ready), 64'b0100);
        push(2'd2, 32'h0000_2002);
        tick();
        pop_check("post_rst");

        chk("sb_empty_at_end", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
Registered N:1 data multiplexer with a valid/ready handshake on every input and on the output. It is the successor to our combinational 2-input select. Selection is made internally by an arbiter, either fixed-priority or round-robin, instead of by an external select line. It sits between multiple producers (e.g. pipeline writeback or memory request sources) and a single consumer, and provides one output register stage.

Parameters:
WIDTH, 32, data width of each source and of the result
NUM_SRC, 4, number of input channels (legal range 2..16)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
SEL_W, $clog2(NUM_SRC), width of the grant index (derived; not to be overridden)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
src_data  input  NUM_SRC*WIDTH  concatenated source data; channel i occupies bits [i*WIDTH +: WIDTH]
src_valid  input  NUM_SRC  per-channel valid
src_ready  output  NUM_SRC  per-channel ready (combinational; at most one bit high)
res  output  WIDTH  registered result data
res_sel  output  SEL_W  registered index of the channel that produced res
res_valid  output  1  result register holds data
res_ready  input  1  consumer accepts res this cycle

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - res_valid=0, res=0, res_sel=0.
  - Round-robin pointer resets to 0.
  - src_ready is all 0 while rst=1.
- Load condition: can_load = !res_valid | res_ready. The output register is empty, or it is being drained this cycle.
- Arbitration (combinational, evaluated only when can_load=1):
  - RR_MODE=0: grant goes to the lowest index i with src_valid[i]=1.
  - RR_MODE=1: grant goes to the first valid index searched from ptr upward, wrapping NUM_SRC-1 → 0.
- src_ready:
  - src_ready[g]=1 only for the granted g, and only when can_load=1 and src_valid[g]=1. All other bits are 0.
  - No bit is ever high when no source is valid.
- Transfer on channel g occurs when src_valid[g] & src_ready[g]. On the next edge:
  - res ← channel g data
  - res_sel ← g
  - res_valid ← 1
- Round-robin pointer: after a transfer from g, ptr ← (g+1) mod NUM_SRC. The pointer is unchanged when no transfer occurs. In RR_MODE=0 the pointer is unused and held at 0.
- Drain without refill: if res_valid & res_ready and no source is valid, then res_valid ← 0 on the next edge. res and res_sel hold their stale values.
- Stall: if res_valid & !res_ready, then res, res_sel and res_valid are held and all src_ready bits are 0.
- Throughput and latency:
  - One transfer per cycle sustained when res_ready=1 continuously (simultaneous drain and load).
  - Latency from input acceptance to res_valid is 1 cycle.
- Input handshake rule: sources must hold src_valid and data until accepted. The block never drops or duplicates a word.
- Fairness: in RR_MODE=1 with k channels continuously valid and res_ready=1, each channel is granted exactly once per k consecutive transfers.
- Reset mid-operation: any word held in the output register is discarded (res_valid→0). Arbitration restarts from ptr=0 after rst deasserts.

Test Plan:
- Reset with all src_valid=1, then release rst → during rst: src_ready=0, res_valid=0. First edge after release: res_valid=1, res_sel=0, res=src0 data.
- RR_MODE=1, NUM_SRC=4, all valid, res_ready=1 for 8 cycles, data[i]=32'h1000+i → res_sel sequence 0,1,2,3,0,1,2,3; res matches data; res_valid stays 1.
- RR_MODE=0, channels 1 and 3 valid, res_ready=1 → channel 1 wins every cycle; src_ready=4'b0010; channel 3 never granted while channel 1 stays valid.
- Backpressure: res_valid=1 holding 32'hDEADBEEF, res_ready=0 for 3 cycles with channel 2 valid → res, res_sel and res_valid held; src_ready=0. When res_ready=1: channel 2 accepted that cycle and appears on res the next cycle.
- Drain to empty: single word on channel 0, then no valids, res_ready=1 → res_valid is 1 for exactly one cycle, then 0; pointer=1.
- Reset asserted mid-stream while res_valid=1 → res_valid drops asynchronously in the same cycle. After release, the first grant in RR_MODE=1 goes to the lowest valid index ≥0.
